car_datapath: RTL and testbench

CAR_DATAPATH -- requirements
Module: car_datapath

---
 rtl/game_pkg.sv | 38 +++
 rtl/sprite_scan.sv | 62 ++++++
 rtl/car_datapath.sv | 167 ++++++++++++++++
 tb/tb_car_datapath.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the game datapaths (car, pedestrian, ...).
//   - Screen geometry (SCREEN_W x SCREEN_H).
//   - Coordinate / colour widths (X_W, Y_W, COLOUR_W).
//   - Sprite scan counter widths (CX_W, CY_W).
//   - 3-bit RGB colour constants.
//   - Horizontal direction type, used when the bounce feature is built in.
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;

  // Offset counter widths for sprite scans (covers sprites up to 32x8).
  localparam int CX_W = 5;
  localparam int CY_W = 3;

  // Colours are {red, green, blue}.
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_BLUE   = 3'b001;
  localparam logic [COLOUR_W-1:0] COLOUR_GREEN  = 3'b010;
  localparam logic [COLOUR_W-1:0] COLOUR_CYAN   = 3'b011;
  localparam logic [COLOUR_W-1:0] COLOUR_RED    = 3'b100;
  localparam logic [COLOUR_W-1:0] COLOUR_PURPLE = 3'b101;
  localparam logic [COLOUR_W-1:0] COLOUR_YELLOW = 3'b110;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE  = 3'b111;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/sprite_scan.sv
// -----------------------------------------------------------------------------
// sprite_scan
// Raster walker over a W x H sprite. Produces the current pixel offset
// (cx, cy) inside the sprite and flags the last pixel of a scan.
//
// Request/response: enable is a level request -- while it is high the walker
// steps one pixel per clock (cx first, then cy); done is high for exactly the
// one cycle in which the final pixel (W-1, H-1) is presented, and on that
// same edge the walker returns to (0,0) so a held enable starts the next scan
// with no idle cycle. Dropping enable returns the walker to (0,0) on the next
// edge, so an interrupted scan always restarts from the first pixel.
//
// Ports:
//   clock   in   rising-edge clock
//   resetn  in   asynchronous active-low reset
//   enable  in   scan request
//   cx      out  column offset, 0..W-1
//   cy      out  row offset,    0..H-1
//   done    out  combinational last-pixel flag
// -----------------------------------------------------------------------------
module sprite_scan
  import game_pkg::*;
#(
  parameter int W    = 27,
  parameter int H    = 5,
  parameter int CX_N = CX_W,
  parameter int CY_N = CY_W
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            enable,
  output logic [CX_N-1:0] cx,
  output logic [CY_N-1:0] cy,
  output logic            done
);

  localparam logic [CX_N-1:0] CX_LAST = CX_N'(W - 1);
  localparam logic [CY_N-1:0] CY_LAST = CY_N'(H - 1);

  logic last_col;
  logic last_row;

  assign last_col = (cx == CX_LAST);
  assign last_row = (cy == CY_LAST);
  assign done     = enable & last_col & last_row;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (!enable) begin
      cx <= '0;
      cy <= '0;
    end else if (last_col) begin
      cx <= '0;
      cy <= last_row ? '0 : cy + 1'b1;
    end else begin
      cx <= cx + 1'b1;
    end
  end

endmodule

// File: rtl/car_datapath.sv
// -----------------------------------------------------------------------------
// car_datapath
// Position register and pixel generator for the player car sprite.
// The car sits on a fixed lane (Y_LANE) and moves horizontally by STEP pixels
// on each can_move strobe. While enable is high the sprite is scanned one
// pixel per clock; each pixel's screen coordinate is presented on
// car_x_final / car_y_final with colour colour_car, and done marks the last.
//
// Build option:
//   CAR_BOUNCE_EN  defined   -> the car bounces between x=0 and
//                               x=SCREEN_W-CAR_W using a direction register.
//                  undefined -> the car wraps around the screen edge.
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   enable       in   scan request (level)
//   can_move     in   one-cycle move strobe; held N cycles moves N steps
//   car_x        out  top-left x of the car
//   car_y        out  top-left y of the car (constant lane)
//   car_x_final  out  x of the pixel presented this cycle
//   car_y_final  out  y of the pixel presented this cycle
//   colour_car   out  pixel colour (constant)
//   done         out  high on the last pixel of a scan
// -----------------------------------------------------------------------------
module car_datapath #(
  parameter int                                SCREEN_W   = game_pkg::SCREEN_W,
  parameter int                                CAR_W      = 27,
  parameter int                                CAR_H      = 5,
  parameter int                                X_START    = 0,
  parameter int                                Y_LANE     = 100,
  parameter int                                STEP       = 4,
  parameter logic [game_pkg::COLOUR_W-1:0]     COLOUR_CAR = game_pkg::COLOUR_RED
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              enable,
  input  logic                              can_move,
  output logic [game_pkg::X_W-1:0]          car_x,
  output logic [game_pkg::Y_W-1:0]          car_y,
  output logic [game_pkg::X_W-1:0]          car_x_final,
  output logic [game_pkg::Y_W-1:0]          car_y_final,
  output logic [game_pkg::COLOUR_W-1:0]     colour_car,
  output logic                              done
);

  localparam int XW  = game_pkg::X_W;
  localparam int YW  = game_pkg::Y_W;
  localparam int CXW = game_pkg::CX_W;
  localparam int CYW = game_pkg::CY_W;

  // One extra bit so sums can be compared against SCREEN_W before truncation.
  localparam logic [XW:0]   SW_EXT    = (XW+1)'(SCREEN_W);
  localparam logic [XW:0]   STEP_EXT  = (XW+1)'(STEP);
  localparam logic [XW-1:0] X_RESET   = XW'(X_START);
  localparam logic [YW-1:0] Y_LANE_V  = YW'(Y_LANE);

  logic [XW-1:0]  px;
  logic [XW-1:0]  px_next;
  logic [XW:0]    step_sum;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [XW:0]    pix_sum;
  logic [XW:0]    pix_wrapped;

  // ---------------------------------------------------------------------------
  // Sprite raster walker
  // ---------------------------------------------------------------------------
  sprite_scan #(
    .W    (CAR_W),
    .H    (CAR_H),
    .CX_N (CXW),
    .CY_N (CYW)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .cx     (cx),
    .cy     (cy),
    .done   (done)
  );

  // ---------------------------------------------------------------------------
  // Horizontal motion
  // ---------------------------------------------------------------------------
  assign step_sum = {1'b0, px} + STEP_EXT;

`ifdef CAR_BOUNCE_EN
  localparam logic [XW:0] X_MAX_EXT = (XW+1)'(SCREEN_W - CAR_W);

  game_pkg::dir_e dir;
  game_pkg::dir_e dir_next;

  // Moving right the car stops flush with the right edge and turns round;
  // moving left it stops at x=0 and turns round. px never leaves
  // 0..SCREEN_W-CAR_W, so the pixel wrap below never fires in this build.
  always_comb begin
    px_next  = px;
    dir_next = dir;
    if (dir == game_pkg::DIR_RIGHT) begin
      if (step_sum > X_MAX_EXT) begin
        px_next  = X_MAX_EXT[XW-1:0];
        dir_next = game_pkg::DIR_LEFT;
      end else begin
        px_next  = step_sum[XW-1:0];
      end
    end else begin
      if ({1'b0, px} < STEP_EXT) begin
        px_next  = '0;
        dir_next = game_pkg::DIR_RIGHT;
      end else begin
        px_next  = px - STEP_EXT[XW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px  <= X_RESET;
      dir <= game_pkg::DIR_RIGHT;
    end else if (can_move) begin
      px  <= px_next;
      dir <= dir_next;
    end
  end
`else
  // STEP <= CAR_W < SCREEN_W, so one conditional subtract keeps px on screen.
  logic [XW:0] step_wrapped;

  assign step_wrapped = step_sum - SW_EXT;

  always_comb begin
    px_next = step_sum[XW-1:0];
    if (step_sum >= SW_EXT) begin
      px_next = step_wrapped[XW-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px <= X_RESET;
    end else if (can_move) begin
      px <= px_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Pixel outputs. A move on the same edge as a scan step only affects the
  // following pixel because these are driven from the current px.
  // ---------------------------------------------------------------------------
  assign pix_sum     = {1'b0, px} + {{(XW+1-CXW){1'b0}}, cx};
  assign pix_wrapped = pix_sum - SW_EXT;

  always_comb begin
    car_x_final = pix_sum[XW-1:0];
    if (pix_sum >= SW_EXT) begin
      car_x_final = pix_wrapped[XW-1:0];
    end
  end

  assign car_y_final = Y_LANE_V + {{(YW-CYW){1'b0}}, cy};
  assign car_x       = px;
  assign car_y       = Y_LANE_V;
  assign colour_car  = COLOUR_CAR;

endmodule

// File: tb/tb_car_datapath.sv
// -----------------------------------------------------------------------------
// tb_car_datapath
// Bench for car_datapath. A main instance with default parameters is followed
// by a model that tracks the car position, the scan pixel index and (in the
// bounce build) the direction; a second instance starts near the right edge
// for the edge-behaviour cases. Build with +define+CAR_BOUNCE_EN for the
// bounce variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_car_datapath;

  localparam int SW      = 320;
  localparam int CW      = 27;
  localparam int CH      = 5;
  localparam int NPIX    = CW * CH;
  localparam int LANE    = 100;
  localparam int STEP    = 4;
  localparam int X0      = 0;
  localparam int COL     = 4;
`ifdef CAR_BOUNCE_EN
  localparam int START2  = 291;
`else
  localparam int START2  = 318;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic       enable = 1'b0, can_move = 1'b0;
  logic [8:0] car_x, car_x_final;
  logic [7:0] car_y, car_y_final;
  logic [2:0] colour_car;
  logic       done;

  logic       en2 = 1'b0, mv2 = 1'b0;
  logic [8:0] car_x2, car_x_final2;
  logic [7:0] car_y2, car_y_final2;
  logic [2:0] colour_car2;
  logic       done2;

  car_datapath dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .can_move    (can_move),
    .car_x       (car_x),
    .car_y       (car_y),
    .car_x_final (car_x_final),
    .car_y_final (car_y_final),
    .colour_car  (colour_car),
    .done        (done)
  );

  car_datapath #(.X_START(START2)) dut2 (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (en2),
    .can_move    (mv2),
    .car_x       (car_x2),
    .car_y       (car_y2),
    .car_x_final (car_x_final2),
    .car_y_final (car_y_final2),
    .colour_car  (colour_car2),
    .done        (done2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: car position, index of the pixel presented (0..NPIX-1,
  // raster order) and direction.
  // ---------------------------------------------------------------------------
  int m_px    = X0;
  int m_k     = 0;
  bit m_right = 1'b1;

  task automatic model_move();
`ifdef CAR_BOUNCE_EN
    if (m_right) begin
      if (m_px + STEP > SW - CW) begin m_px = SW - CW; m_right = 1'b0; end
      else m_px = m_px + STEP;
    end else begin
      if (m_px < STEP) begin m_px = 0; m_right = 1'b1; end
      else m_px = m_px - STEP;
    end
`else
    m_px = (m_px + STEP) % SW;
`endif
  endtask

  // Compare process: mid-cycle, inputs stable; then advance the model across
  // the coming rising edge.
  always @(negedge clock) begin
    if (!resetn) begin
      m_px = X0; m_k = 0; m_right = 1'b1;
      check("rst_car_x",   int'(car_x),       X0);
      check("rst_x_final", int'(car_x_final), X0);
      check("rst_y_final", int'(car_y_final), LANE);
      check("rst_done",    int'(done),        0);
    end else begin
      check("car_x",   int'(car_x),       m_px);
      check("car_y",   int'(car_y),       LANE);
      check("x_final", int'(car_x_final), (m_px + m_k % CW) % SW);
      check("y_final", int'(car_y_final), LANE + m_k / CW);
      check("colour",  int'(colour_car),  COL);
      check("done",    int'(done),        int'(enable && m_k == NPIX - 1));
      if (can_move) model_move();
      m_k = enable ? (m_k + 1) % NPIX : 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic en, input logic mv);
    @(posedge clock); #1;
    enable = en; can_move = mv;
  endtask

  task automatic drive2(input logic en, input logic mv);
    @(posedge clock); #1;
    en2 = en; mv2 = mv;
  endtask

  task automatic set_reset(input logic v);
    @(posedge clock); #1;
    resetn = v;
  endtask

  task automatic peek_main(input string name, input int x, input int y, input int d);
    #3;
    check({name, "_x"},    int'(car_x_final), x);
    check({name, "_y"},    int'(car_y_final), y);
    check({name, "_done"}, int'(done),        d);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    set_reset(1'b0);
    #3;
    check("lit_rst_car_x",  int'(car_x),       0);
    check("lit_rst_colour", int'(colour_car),  4);
    check("lit_rst_car_x2", int'(car_x2),      START2);
    peek_main("lit_rst", 0, 100, 0);
    set_reset(1'b1);
    drive(1'b0, 1'b0);

    // One full scan plus the first pixel of the next
    for (int i = 1; i <= NPIX + 1; i++) begin
      drive(1'b1, 1'b0);
      if (i == 1)   peek_main("scan_first",   0,  100, 0);
      if (i == 27)  peek_main("scan_row0end", 26, 100, 0);
      if (i == 28)  peek_main("scan_row1",    0,  101, 0);
      if (i == 134) peek_main("scan_pre",     25, 104, 0);
      if (i == 135) peek_main("scan_last",    26, 104, 1);
      if (i == 136) peek_main("scan_again",   0,  100, 0);
    end

    // Abort after 10 pixels, then restart
    drive(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    peek_main("abort_restart", 0, 100, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);

    // Reset asserted on scan cycle 50
    drive(1'b0, 1'b0);
    for (int i = 0; i < 49; i++) drive(1'b1, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    check("midrst_x",    int'(car_x_final), 0);
    check("midrst_y",    int'(car_y_final), 100);
    check("midrst_done", int'(done),        0);
    drive(1'b1, 1'b0);
    set_reset(1'b1);
    peek_main("midrst_restart", 0, 100, 0);

    // Move on the cycle presenting cx=5 (px is 0 here)
    drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    peek_main("move_old_px", 5, 100, 0);
    drive(1'b1, 1'b0);
    peek_main("move_new_px", 10, 100, 0);
    check("move_car_x", int'(car_x), 4);
    drive(1'b0, 1'b0);

    // Edge behaviour on the second instance
`ifdef CAR_BOUNCE_EN
    drive2(1'b0, 1'b1);
    drive2(1'b0, 1'b0);
    #3;
    check("bounce_clamp", int'(car_x2), 293);
    drive2(1'b1, 1'b0);
    #3;
    check("bounce_no_wrap", int'(car_x_final2), 293);
    drive2(1'b0, 1'b1);
    drive2(1'b0, 1'b0);
    #3;
    check("bounce_left", int'(car_x2), 289);
`else
    drive2(1'b1, 1'b0); #3; check("wrap_pix0", int'(car_x_final2), 318);
    drive2(1'b1, 1'b0); #3; check("wrap_pix1", int'(car_x_final2), 319);
    drive2(1'b1, 1'b0); #3; check("wrap_pix2", int'(car_x_final2), 0);
    drive2(1'b1, 1'b0); #3; check("wrap_pix3", int'(car_x_final2), 1);
    drive2(1'b0, 1'b1);
    drive2(1'b0, 1'b0);
    #3;
    check("wrap_px",   int'(car_x2),       2);
    check("wrap_pixf", int'(car_x_final2), 2);
`endif

    // Randomised traffic, occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      resetn   = ($urandom_range(0, 299) != 0);
      enable   = ($urandom_range(0, 9) != 0);
      can_move = ($urandom_range(0, 3) == 0);
    end
    @(posedge clock); #1;
    resetn = 1'b1; enable = 1'b0; can_move = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
